// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute unit with valid/ready handshakes on both sides.
// Single-cycle integer ops finish one cycle after accept. MUL/MULHU use
// shift-add and DIVU/REMU use restoring division, both one bit per cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for an operation; in_ready high
// BUSY  | operands latched; iterating (multi-cycle) or evaluating (single)
// DONE  | out_result/out_tag/out_dbz held with out_valid until out_ready

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dbz
);

   localparam int SH = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_SLT   = 4'd2;
   localparam logic [3:0] OP_SLTU  = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_SLL   = 4'd8;
   localparam logic [3:0] OP_SRL   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;
   localparam logic [3:0] OP_LUI   = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [SH-1:0]     cnt_q, cnt_d;
   logic              fin_q, fin_d;
   logic [3:0]        op_q, op_d;
   logic [WIDTH-1:0]  src1_q, src1_d;
   logic [WIDTH-1:0]  src2_q, src2_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  out_result_q, out_result_d;
   logic [TAG_W-1:0]  out_tag_q, out_tag_d;
   logic              out_dbz_q, out_dbz_d;

   logic [WIDTH:0]    sub_full;
   logic              slt_bit;
   logic              sltu_bit;
   logic [SH-1:0]     shamt;
   logic [WIDTH-1:0]  alu_res;

   logic              op_multi;
   logic              in_multi;
   logic [WIDTH:0]    mul_sum;
   logic [WIDTH:0]    div_r;
   logic [WIDTH+1:0]  div_trial;
   logic              div_ge;
   logic [WIDTH-1:0]  iter_hi;
   logic [WIDTH-1:0]  iter_lo;
   logic [WIDTH-1:0]  multi_res;

   assign in_ready   = (state_q == IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = out_result_q;
   assign out_tag    = out_tag_q;
   assign out_dbz    = out_dbz_q;

   // Opcodes 12..15 all have op[3:2] = 2'b11; op[1] picks divide, op[0] the upper/remainder half.
   assign op_multi = op_q[3] & op_q[2];
   assign in_multi = in_op[3] & in_op[2];

   // Single-cycle ALU on the latched operands; SUB/SLT/SLTU share one adder.
   always_comb begin
      sub_full = {1'b0, src1_q} + {1'b0, ~src2_q} + {{WIDTH{1'b0}}, 1'b1};
      sltu_bit = ~sub_full[WIDTH];
      slt_bit  = (src1_q[WIDTH-1] != src2_q[WIDTH-1]) ? src1_q[WIDTH-1]
                                                      : sub_full[WIDTH-1];
      shamt    = src1_q[SH-1:0];
      alu_res  = '0;
      case (op_q)
         OP_ADD:  alu_res = src1_q + src2_q;
         OP_SUB:  alu_res = sub_full[WIDTH-1:0];
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
         OP_AND:  alu_res = src1_q & src2_q;
         OP_NOR:  alu_res = ~(src1_q | src2_q);
         OP_OR:   alu_res = src1_q | src2_q;
         OP_XOR:  alu_res = src1_q ^ src2_q;
         OP_SLL:  alu_res = src2_q << shamt;
         OP_SRL:  alu_res = src2_q >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(src2_q) >>> shamt);
         OP_LUI:  alu_res = {src2_q[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
         default: alu_res = '0;
      endcase
   end

   // One iteration of shift-add multiply or restoring divide over {hi, lo}.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, src1_q} : {(WIDTH+1){1'b0}});
      div_r     = {hi_q, lo_q[WIDTH-1]};
      div_trial = {1'b0, div_r} - {2'b00, src2_q};
      div_ge    = ~div_trial[WIDTH+1];
      if (op_q[1]) begin
         iter_hi = div_ge ? div_trial[WIDTH-1:0] : div_r[WIDTH-1:0];
         iter_lo = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         iter_hi = mul_sum[WIDTH:1];
         iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      multi_res = op_q[0] ? hi_q : lo_q;
   end

   // Next-state, operand capture, iteration and result-register update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fin_d        = fin_q;
      op_d         = op_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      tag_d        = tag_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      out_result_d = out_result_q;
      out_tag_d    = out_tag_q;
      out_dbz_d    = out_dbz_q;

      case (state_q)
         IDLE: begin
            if (in_valid && !flush) begin
               op_d    = in_op;
               src1_d  = in_src1;
               src2_d  = in_src2;
               tag_d   = in_tag;
               cnt_d   = SH'(WIDTH - 1);
               // Single-cycle ops skip iteration and resolve on the first BUSY edge.
               fin_d   = ~in_multi;
               hi_d    = '0;
               lo_d    = in_op[1] ? in_src1 : in_src2;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (flush) begin
               state_d = IDLE;
            end else if (fin_q) begin
               out_result_d = op_multi ? multi_res : alu_res;
               out_tag_d    = tag_q;
               out_dbz_d    = op_multi & op_q[1] & (src2_q == '0);
               state_d      = DONE;
            end else begin
               hi_d = iter_hi;
               lo_d = iter_lo;
               if (cnt_q == '0) begin
                  fin_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - SH'(1);
               end
            end
         end
         DONE: begin
            if (flush || out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         fin_q        <= 1'b0;
         op_q         <= '0;
         src1_q       <= '0;
         src2_q       <= '0;
         tag_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         out_result_q <= '0;
         out_tag_q    <= '0;
         out_dbz_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fin_q        <= fin_d;
         op_q         <= op_d;
         src1_q       <= src1_d;
         src2_q       <= src2_d;
         tag_q        <= tag_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         out_result_q <= out_result_d;
         out_tag_q    <= out_tag_d;
         out_dbz_q    <= out_dbz_d;
      end
   end

endmodule
